// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detect, LSB-first data, stop check.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD) between data and stop.
module uart_rx_deframer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD   = 1'b0
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
   localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd5;
`endif

   logic                 rx_meta_q, rx_s_q;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 strobe;
   logic                 good;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      good        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      strobe = (state_q == ST_START) ? (baud_q == HALF_TC)
                                     : (baud_q == FULL_TC);

      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) state_d = ST_START;
         end
         ST_START: begin
            if (strobe) state_d = rx_s_q ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (strobe) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (strobe) begin
               par_bad_d = rx_s_q ^ (^shift_q) ^ PARITY_ODD;
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (strobe) begin
`ifdef UART_RX_PARITY_EN
               parity_err_d = par_bad_q;
               good         = rx_s_q & ~par_bad_q;
`else
               good         = rx_s_q;
`endif
               frame_err_d = ~rx_s_q;
               state_d     = rx_s_q ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rx_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter restarts on every state change so each phase times from entry.
      if (state_d != state_q || strobe ||
          state_q == ST_IDLE || state_q == ST_BREAK)
         baud_d = '0;
      else
         baud_d = baud_q + CW'(1);

      if (good) begin
         if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
         end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= ST_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
